apb_burst_scheduler: RTL and testbench

- Shares the bridge's single APB master between the AXI read path and the AXI write path.
- Arbitrates round-robin at burst granularity.
- Owns the granted burst and expands it into per-beat APB commands, generating each beat address for FIXED, INCR and WRAP bursts.
- Reports per-beat progress and a final burst response to the owning path.
- Sits between the read/write channel front-ends and the APB master FSM.

---
 rtl/apb_burst_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_apb_burst_scheduler.sv | 513 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_burst_scheduler.sv
// APB burst scheduler: round-robin read/write arbitration at burst
// granularity and expansion of the granted burst into APB beats.
module apb_burst_scheduler #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [3:0]            rd_len,
    input  logic [2:0]            rd_size,
    input  logic [1:0]            rd_burst,
    output logic                  rd_gnt,
    output logic                  rd_beat,
    output logic                  rd_last,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [3:0]            wr_len,
    input  logic [2:0]            wr_size,
    input  logic [1:0]            wr_burst,
    output logic                  wr_gnt,
    output logic                  wr_beat,
    output logic                  wr_last,
    output logic                  cmd_valid,
    output logic                  cmd_write,
    output logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic                  cmd_ready,
    input  logic                  cmd_done,
    input  logic                  cmd_slverr,
    output logic [1:0]            resp,
    output logic                  resp_valid
);

    if (DATA_WIDTH < 8) begin : g_dw_chk
        $error("DATA_WIDTH must be at least 8");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

    state_t                r_state;
    logic                  r_owner;
    logic                  r_last_owner;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [3:0]            r_len;
    logic [2:0]            r_size;
    logic                  r_wrap;
    logic                  r_fixed;
    logic                  r_bad;
    logic [3:0]            r_cnt;
    logic                  r_err;

    logic                  w_sel_wr;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [3:0]            w_sel_len;
    logic [2:0]            w_sel_size;
    logic [1:0]            w_sel_burst;
    logic                  w_len_ok;
    logic [ADDR_WIDTH-1:0] w_step;
    logic [ADDR_WIDTH-1:0] w_cont;
    logic [ADDR_WIDTH-1:0] w_mask;
    logic [ADDR_WIDTH-1:0] w_inc;
    logic [ADDR_WIDTH-1:0] w_next;
    logic                  w_fin;
    logic                  w_end;

    // On contention the path that did not own the last burst wins
    assign w_sel_wr    = wr_req & (~rd_req | ~r_last_owner);
    assign w_sel_addr  = w_sel_wr ? wr_addr  : rd_addr;
    assign w_sel_len   = w_sel_wr ? wr_len   : rd_len;
    assign w_sel_size  = w_sel_wr ? wr_size  : rd_size;
    assign w_sel_burst = w_sel_wr ? wr_burst : rd_burst;
    assign w_len_ok    = (w_sel_len == 4'd1) | (w_sel_len == 4'd3) |
                         (w_sel_len == 4'd7) | (w_sel_len == 4'd15);

    // Next beat address for FIXED, INCR and WRAP
    assign w_step = ONE << r_size;
    assign w_cont = ADDR_WIDTH'({1'b0, r_len} + 5'd1) << r_size;
    assign w_mask = w_cont - ONE;
    assign w_inc  = r_addr + w_step;
    assign w_next = r_fixed ? r_addr :
                    r_wrap  ? ((r_addr & ~w_mask) | (w_inc & w_mask)) :
                              w_inc;

    // Beat completion pulses follow cmd_done in the same cycle
    assign w_fin   = (r_state == S_WAIT) & cmd_done;
    assign w_end   = w_fin & (r_cnt == r_len);
    assign rd_beat = w_fin & ~r_owner;
    assign rd_last = w_end & ~r_owner;
    assign wr_beat = w_fin & r_owner;
    assign wr_last = w_end & r_owner;

    // Burst FSM with registered grant, command and response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            r_addr       <= '0;
            r_len        <= '0;
            r_size       <= '0;
            r_wrap       <= 1'b0;
            r_fixed      <= 1'b0;
            r_bad        <= 1'b0;
            r_cnt        <= '0;
            r_err        <= 1'b0;
            rd_gnt       <= 1'b0;
            wr_gnt       <= 1'b0;
            cmd_valid    <= 1'b0;
            cmd_write    <= 1'b0;
            cmd_addr     <= '0;
            resp         <= 2'b00;
            resp_valid   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (rd_req | wr_req) begin
                        r_owner   <= w_sel_wr;
                        r_addr    <= w_sel_addr;
                        r_len     <= w_sel_len;
                        r_size    <= w_sel_size;
                        r_fixed   <= (w_sel_burst == 2'b00);
                        r_wrap    <= (w_sel_burst == 2'b10) & w_len_ok;
                        r_bad     <= (w_sel_burst == 2'b11) |
                                     ((w_sel_burst == 2'b10) & ~w_len_ok);
                        r_cnt     <= '0;
                        r_err     <= 1'b0;
                        rd_gnt    <= ~w_sel_wr;
                        wr_gnt    <= w_sel_wr;
                        cmd_valid <= 1'b1;
                        cmd_write <= w_sel_wr;
                        cmd_addr  <= w_sel_addr;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        r_state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cmd_done) begin
                        r_err <= r_err | cmd_slverr;
                        if (r_cnt == r_len) begin
                            resp_valid <= 1'b1;
                            resp       <= (r_err | cmd_slverr | r_bad) ?
                                          2'b10 : 2'b00;
                            r_state    <= S_DONE;
                        end else begin
                            r_cnt     <= r_cnt + 4'd1;
                            r_addr    <= w_next;
                            cmd_addr  <= w_next;
                            cmd_valid <= 1'b1;
                            r_state   <= S_ISSUE;
                        end
                    end
                end
                S_DONE: begin
                    resp_valid   <= 1'b0;
                    resp         <= 2'b00;
                    rd_gnt       <= 1'b0;
                    wr_gnt       <= 1'b0;
                    cmd_write    <= 1'b0;
                    cmd_addr     <= '0;
                    r_last_owner <= r_owner;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_burst_scheduler.sv
// Directed bench for apb_burst_scheduler with a small APB responder
// and a monitor that logs accepted commands, beats and responses.
module tb_apb_burst_scheduler;

    logic        clk;
    logic        rst_n;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic [3:0]  rd_len;
    logic [2:0]  rd_size;
    logic [1:0]  rd_burst;
    logic        rd_gnt;
    logic        rd_beat;
    logic        rd_last;
    logic        wr_req;
    logic [31:0] wr_addr;
    logic [3:0]  wr_len;
    logic [2:0]  wr_size;
    logic [1:0]  wr_burst;
    logic        wr_gnt;
    logic        wr_beat;
    logic        wr_last;
    logic        cmd_valid;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic        cmd_ready;
    logic        cmd_done;
    logic        cmd_slverr;
    logic [1:0]  resp;
    logic        resp_valid;

    apb_burst_scheduler #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len),
        .rd_size(rd_size), .rd_burst(rd_burst),
        .rd_gnt(rd_gnt), .rd_beat(rd_beat), .rd_last(rd_last),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len),
        .wr_size(wr_size), .wr_burst(wr_burst),
        .wr_gnt(wr_gnt), .wr_beat(wr_beat), .wr_last(wr_last),
        .cmd_valid(cmd_valid), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_ready(cmd_ready),
        .cmd_done(cmd_done), .cmd_slverr(cmd_slverr),
        .resp(resp), .resp_valid(resp_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;

    // responder controls (written by the main process only)
    bit auto_en = 1'b1;
    int err_beat = -1;
    bit m_ready = 1'b0;
    bit m_done = 1'b0;

    // monitor state (written by the monitor process only)
    logic [31:0] addr_log[$];
    bit          wrt_log[$];
    bit          gnt_log[$];
    int rd_beats = 0, wr_beats = 0, rd_lasts = 0, wr_lasts = 0;
    int rd_last_at = 0, wr_last_at = 0;
    int resp_cnt = 0, overlap = 0;
    logic [1:0] last_resp = 2'b00;
    int beat_no = 0;
    int rsp_st = 0;
    bit p_rd = 1'b0, p_wr = 1'b0;

    // responder drives at negedge+1, monitor samples at negedge+2
    always begin
        @(negedge clk);
        #1;
        if (auto_en) begin
            cmd_ready = 1'b0;
            cmd_done = 1'b0;
            cmd_slverr = 1'b0;
            if (rsp_st == 0) begin
                if (cmd_valid) begin
                    cmd_ready = 1'b1;
                    rsp_st = 1;
                end
            end else begin
                cmd_done = 1'b1;
                cmd_slverr = (err_beat == beat_no);
                beat_no++;
                rsp_st = 0;
            end
        end else begin
            rsp_st = 0;
            cmd_ready = m_ready;
            cmd_done = m_done;
            cmd_slverr = 1'b0;
        end
        #1;
        if (cmd_valid && cmd_ready) begin
            addr_log.push_back(cmd_addr);
            wrt_log.push_back(cmd_write);
        end
        if (rd_beat) rd_beats++;
        if (wr_beat) wr_beats++;
        if (rd_last) begin rd_lasts++; rd_last_at = rd_beats; end
        if (wr_last) begin wr_lasts++; wr_last_at = wr_beats; end
        if (resp_valid) begin
            resp_cnt++;
            last_resp = resp;
            beat_no = 0;
        end
        if (rd_gnt && wr_gnt) overlap++;
        if (rd_gnt && !p_rd) gnt_log.push_back(1'b0);
        if (wr_gnt && !p_wr) gnt_log.push_back(1'b1);
        p_rd = rd_gnt;
        p_wr = wr_gnt;
    end

    task automatic wait_resp(input int target, input int budget);
        int n = 0;
        while (resp_cnt < target && n < budget) begin
            @(negedge clk);
            #3;
            n++;
        end
        if (resp_cnt < target) begin
            total++;
            $display("FAIL resp_timeout got %0d want %0d", resp_cnt, target);
        end
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < budget) begin
            @(negedge clk);
            #3;
            seen = cmd_valid;
            n++;
        end
        if (!seen) begin
            total++;
            $display("FAIL valid_timeout after %0d cycles", n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #3;
        total++;
        if ({rd_gnt, wr_gnt, rd_beat, rd_last, wr_beat, wr_last,
             cmd_valid, cmd_write, resp_valid, resp} !== 11'd0)
            $display("FAIL reset_ctrl got %b want 0",
                     {rd_gnt, wr_gnt, rd_beat, rd_last, wr_beat,
                      wr_last, cmd_valid, cmd_write, resp_valid, resp});
        else passed++;
        total++;
        if (cmd_addr !== 32'h0)
            $display("FAIL reset_addr got %h want 0", cmd_addr);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_incr_read();
        int a0 = addr_log.size();
        int rb0 = rd_beats;
        int rl0 = rd_lasts;
        int r0 = resp_cnt;
        logic [31:0] exp;
        rd_addr = 32'h100; rd_len = 4'd3; rd_size = 3'd2;
        rd_burst = 2'b01; rd_req = 1'b1;
        wait_resp(r0 + 1, 100);
        rd_req = 1'b0;
        total++;
        if (addr_log.size() - a0 !== 4)
            $display("FAIL incr_ncmd got %0d want 4", addr_log.size() - a0);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            exp = 32'h100 + 32'(4 * i);
            if (addr_log.size() > a0 + i) begin
                total++;
                if (addr_log[a0+i] !== exp || wrt_log[a0+i] !== 1'b0)
                    $display("FAIL incr_addr%0d got %h/%b want %h/0", i,
                             addr_log[a0+i], wrt_log[a0+i], exp);
                else passed++;
            end
        end
        total++;
        if (rd_beats - rb0 !== 4 || rd_lasts - rl0 !== 1)
            $display("FAIL incr_beats got %0d/%0d want 4/1",
                     rd_beats - rb0, rd_lasts - rl0);
        else passed++;
        total++;
        if (rd_last_at !== rb0 + 4)
            $display("FAIL incr_lastpos got %0d want %0d",
                     rd_last_at - rb0, 4);
        else passed++;
        total++;
        if (last_resp !== 2'b00)
            $display("FAIL incr_resp got %b want 00", last_resp);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_wrap_write();
        int a0 = addr_log.size();
        int wb0 = wr_beats;
        int r0 = resp_cnt;
        logic [31:0] ex [4];
        ex = '{32'h38, 32'h3C, 32'h30, 32'h34};
        wr_addr = 32'h38; wr_len = 4'd3; wr_size = 3'd2;
        wr_burst = 2'b10; wr_req = 1'b1;
        wait_resp(r0 + 1, 100);
        wr_req = 1'b0;
        total++;
        if (addr_log.size() - a0 !== 4)
            $display("FAIL wrap_ncmd got %0d want 4", addr_log.size() - a0);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            if (addr_log.size() > a0 + i) begin
                total++;
                if (addr_log[a0+i] !== ex[i] || wrt_log[a0+i] !== 1'b1)
                    $display("FAIL wrap_addr%0d got %h/%b want %h/1", i,
                             addr_log[a0+i], wrt_log[a0+i], ex[i]);
                else passed++;
            end
        end
        total++;
        if (wr_beats - wb0 !== 4 || wr_last_at !== wb0 + 4)
            $display("FAIL wrap_last got %0d/%0d want 4/4",
                     wr_beats - wb0, wr_last_at - wb0);
        else passed++;
        total++;
        if (last_resp !== 2'b00)
            $display("FAIL wrap_resp got %b want 00", last_resp);
        else passed++;
        @(negedge clk);
    endtask

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [1:0]  resp;
        logic [2:0]  n;
    } vec_t;

    task automatic test_addr_modes();
        vec_t v [5];
        logic [31:0] ea [5][3];
        v[0] = '{wr:1'b0, addr:32'h80, len:4'd2, size:3'd2,
                 burst:2'b00, resp:2'b00, n:3'd3};
        ea[0] = '{32'h80, 32'h80, 32'h80};
        v[1] = '{wr:1'b1, addr:32'h10, len:4'd2, size:3'd0,
                 burst:2'b10, resp:2'b10, n:3'd3};
        ea[1] = '{32'h10, 32'h11, 32'h12};
        v[2] = '{wr:1'b0, addr:32'hFFFFFFFC, len:4'd1, size:3'd2,
                 burst:2'b11, resp:2'b10, n:3'd2};
        ea[2] = '{32'hFFFFFFFC, 32'h0, 32'h0};
        v[3] = '{wr:1'b1, addr:32'h1000, len:4'd1, size:3'd7,
                 burst:2'b01, resp:2'b00, n:3'd2};
        ea[3] = '{32'h1000, 32'h1080, 32'h0};
        v[4] = '{wr:1'b0, addr:32'h28, len:4'd1, size:3'd3,
                 burst:2'b10, resp:2'b00, n:3'd2};
        ea[4] = '{32'h28, 32'h20, 32'h0};
        for (int k = 0; k < 5; k++) begin
            int a0 = addr_log.size();
            int b0 = v[k].wr ? wr_beats : rd_beats;
            int r0 = resp_cnt;
            int nb;
            if (v[k].wr) begin
                wr_addr = v[k].addr; wr_len = v[k].len;
                wr_size = v[k].size; wr_burst = v[k].burst;
                wr_req = 1'b1;
            end else begin
                rd_addr = v[k].addr; rd_len = v[k].len;
                rd_size = v[k].size; rd_burst = v[k].burst;
                rd_req = 1'b1;
            end
            wait_resp(r0 + 1, 100);
            rd_req = 1'b0;
            wr_req = 1'b0;
            nb = (v[k].wr ? wr_beats : rd_beats) - b0;
            total++;
            if (nb !== int'(v[k].n) || addr_log.size() - a0 !== int'(v[k].n))
                $display("FAIL mode%0d_beats got %0d/%0d want %0d", k,
                         nb, addr_log.size() - a0, v[k].n);
            else passed++;
            for (int j = 0; j < int'(v[k].n); j++) begin
                if (addr_log.size() > a0 + j) begin
                    total++;
                    if (addr_log[a0+j] !== ea[k][j])
                        $display("FAIL mode%0d_addr%0d got %h want %h",
                                 k, j, addr_log[a0+j], ea[k][j]);
                    else passed++;
                end
            end
            total++;
            if (last_resp !== v[k].resp)
                $display("FAIL mode%0d_resp got %b want %b", k,
                         last_resp, v[k].resp);
            else passed++;
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int a0;
        int g0;
        int r0;
        bit eg [3];
        logic [31:0] ex [3];
        eg = '{1'b0, 1'b1, 1'b0};
        ex = '{32'h200, 32'h300, 32'h200};
        rst_n = 1'b0;
        rd_addr = 32'h200; rd_len = 4'd0; rd_size = 3'd2; rd_burst = 2'b01;
        wr_addr = 32'h300; wr_len = 4'd0; wr_size = 3'd2; wr_burst = 2'b01;
        rd_req = 1'b1;
        wr_req = 1'b1;
        @(negedge clk);
        #3;
        a0 = addr_log.size();
        g0 = gnt_log.size();
        r0 = resp_cnt;
        rst_n = 1'b1;
        wait_resp(r0 + 3, 100);
        rd_req = 1'b0;
        wr_req = 1'b0;
        total++;
        if (gnt_log.size() - g0 !== 3)
            $display("FAIL b2b_ngnt got %0d want 3", gnt_log.size() - g0);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            if (gnt_log.size() > g0 + i && addr_log.size() > a0 + i) begin
                total++;
                if (gnt_log[g0+i] !== eg[i] || addr_log[a0+i] !== ex[i] ||
                    wrt_log[a0+i] !== eg[i])
                    $display("FAIL b2b_order%0d got %b/%h want %b/%h", i,
                             gnt_log[g0+i], addr_log[a0+i], eg[i], ex[i]);
                else passed++;
            end
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_slverr();
        int a0 = addr_log.size();
        int rb0 = rd_beats;
        int r0 = resp_cnt;
        err_beat = 0;
        rd_addr = 32'h40; rd_len = 4'd1; rd_size = 3'd2;
        rd_burst = 2'b01; rd_req = 1'b1;
        wait_resp(r0 + 1, 100);
        rd_req = 1'b0;
        err_beat = -1;
        total++;
        if (rd_beats - rb0 !== 2 || addr_log.size() - a0 !== 2)
            $display("FAIL slverr_beats got %0d/%0d want 2",
                     rd_beats - rb0, addr_log.size() - a0);
        else passed++;
        if (addr_log.size() > a0 + 1) begin
            total++;
            if (addr_log[a0+1] !== 32'h44)
                $display("FAIL slverr_addr1 got %h want 44", addr_log[a0+1]);
            else passed++;
        end
        total++;
        if (last_resp !== 2'b10)
            $display("FAIL slverr_resp got %b want 10", last_resp);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_stall();
        int a0 = addr_log.size();
        int rb0 = rd_beats;
        int r0 = resp_cnt;
        auto_en = 1'b0;
        m_ready = 1'b0;
        m_done = 1'b0;
        rd_addr = 32'h500; rd_len = 4'd0; rd_size = 3'd2;
        rd_burst = 2'b01; rd_req = 1'b1;
        wait_valid(20);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            m_ready = 1'b0;
            m_done = (i == 2);
            #3;
            total++;
            if (cmd_valid !== 1'b1 || cmd_addr !== 32'h500 || rd_beat !== 1'b0)
                $display("FAIL stall%0d got %b/%h/%b want 1/500/0", i,
                         cmd_valid, cmd_addr, rd_beat);
            else passed++;
        end
        @(negedge clk);
        m_ready = 1'b1;
        m_done = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        m_done = 1'b1;
        @(negedge clk);
        m_done = 1'b0;
        wait_resp(r0 + 1, 20);
        rd_req = 1'b0;
        total++;
        if (rd_beats - rb0 !== 1 || addr_log.size() - a0 !== 1)
            $display("FAIL stall_beats got %0d/%0d want 1/1",
                     rd_beats - rb0, addr_log.size() - a0);
        else passed++;
        total++;
        if (last_resp !== 2'b00)
            $display("FAIL stall_resp got %b want 00", last_resp);
        else passed++;
        auto_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int rb0 = rd_beats;
        int r0 = resp_cnt;
        int a1;
        int r1;
        auto_en = 1'b0;
        rd_addr = 32'h600; rd_len = 4'd3; rd_size = 3'd2;
        rd_burst = 2'b01; rd_req = 1'b1;
        wait_valid(20);
        @(negedge clk);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        m_done = 1'b1;
        @(negedge clk);
        m_done = 1'b0;
        wait_valid(20);
        @(negedge clk);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        rst_n = 1'b0;
        #2;
        total++;
        if ({rd_gnt, wr_gnt, rd_beat, rd_last, wr_beat, wr_last,
             cmd_valid, cmd_write, resp_valid, resp} !== 11'd0 ||
            cmd_addr !== 32'h0)
            $display("FAIL midrst_out got %b/%h want 0/0",
                     {rd_gnt, wr_gnt, cmd_valid, resp_valid}, cmd_addr);
        else passed++;
        total++;
        if (rd_beats - rb0 !== 1)
            $display("FAIL midrst_beats got %0d want 1", rd_beats - rb0);
        else passed++;
        rd_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        auto_en = 1'b1;
        @(negedge clk);
        #3;
        a1 = addr_log.size();
        r1 = resp_cnt;
        total++;
        if (r1 !== r0)
            $display("FAIL midrst_noresp got %0d want %0d", r1, r0);
        else passed++;
        @(negedge clk);
        wr_addr = 32'h700; wr_len = 4'd1; wr_size = 3'd2;
        wr_burst = 2'b01; wr_req = 1'b1;
        wait_resp(r1 + 1, 100);
        wr_req = 1'b0;
        total++;
        if (addr_log.size() - a1 !== 2)
            $display("FAIL midrst_ncmd got %0d want 2", addr_log.size() - a1);
        else passed++;
        if (addr_log.size() > a1 + 1) begin
            total++;
            if (addr_log[a1] !== 32'h700 || addr_log[a1+1] !== 32'h704)
                $display("FAIL midrst_addr got %h,%h want 700,704",
                         addr_log[a1], addr_log[a1+1]);
            else passed++;
        end
        total++;
        if (last_resp !== 2'b00)
            $display("FAIL midrst_resp got %b want 00", last_resp);
        else passed++;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        rd_req = 1'b0; rd_addr = '0; rd_len = '0;
        rd_size = '0; rd_burst = '0;
        wr_req = 1'b0; wr_addr = '0; wr_len = '0;
        wr_size = '0; wr_burst = '0;
        cmd_ready = 1'b0; cmd_done = 1'b0; cmd_slverr = 1'b0;
        test_reset();
        test_incr_read();
        test_wrap_write();
        test_addr_modes();
        test_back_to_back();
        test_slverr();
        test_stall();
        test_reset_mid();
        total++;
        if (overlap !== 0)
            $display("FAIL gnt_overlap got %0d want 0", overlap);
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
